// File: rtl/mcseq_pkg.sv
// Shared types and default constants for the multi-cycle instruction sequencer.
package mcseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } mcseq_state_t;

  localparam int unsigned DEF_MUL_CYCLES = 32;
  localparam int unsigned DEF_MAX_LEN    = 1024;

endpackage : mcseq_pkg

// File: rtl/step_counter.sv
// Up-counter with synchronous clear, increment enable and terminal-count compare.
module step_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         at_term
);

  // Clear has priority over increment; the controller never asks for both.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term_val);

endmodule : step_counter

// File: rtl/multicycle_seq_ctrl.sv
// Sequencer for MEMCOPY and MUL: holds the PC, steps the copy index or the
// multiplier step, and opens the writeback gate for a single retire cycle.
module multicycle_seq_ctrl
  import mcseq_pkg::*;
#(
  parameter int unsigned IDX_W      = 32,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          memcopy,
  input  logic                          mul,
  input  logic [IDX_W-1:0]              copy_len,
  output logic                          pc_en,
  output logic                          wb_en,
  output logic                          copy_we,
  output logic [IDX_W-1:0]              copy_idx,
  output logic                          mul_start,
  output logic [$clog2(MUL_CYCLES)-1:0] mul_step,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned STEP_W = $clog2(MUL_CYCLES);

  mcseq_state_t     state_q, state_d, cur_state;
  logic [IDX_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  logic             len_over;
  logic [IDX_W-1:0] len_clamped;

  logic             idx_clr, idx_inc, idx_term;
  logic             step_clr, step_inc, step_term;
  logic [IDX_W-1:0] idx_q;
  logic [STEP_W-1:0] step_q;

  // Requested length clamped to the largest supported copy.
  assign len_over    = (copy_len > IDX_W'(MAX_LEN));
  assign len_clamped = len_over ? IDX_W'(MAX_LEN) : copy_len;

  // Copy element index; terminal at the last element of the latched length.
  step_counter #(.W(IDX_W)) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (idx_clr),
    .inc      (idx_inc),
    .term_val (len_q - IDX_W'(1)),
    .count    (idx_q),
    .at_term  (idx_term)
  );

  // Multiplier iteration; terminal at the final iteration.
  step_counter #(.W(STEP_W)) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (step_clr),
    .inc      (step_inc),
    .term_val (STEP_W'(MUL_CYCLES - 1)),
    .count    (step_q),
    .at_term  (step_term)
  );

  // State, latched length and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Next-state and combinational outputs; reset cycle behaves as IDLE.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    err_d     = err_q;
    pc_en     = 1'b0;
    wb_en     = 1'b0;
    copy_we   = 1'b0;
    mul_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    step_clr  = 1'b0;
    step_inc  = 1'b0;
    cur_state = rst ? IDLE : state_q;

    case (cur_state)
      IDLE: begin
        idx_clr  = 1'b1;
        step_clr = 1'b1;
        if (memcopy) begin
          // MEMCOPY wins when both decodes are present; that case is flagged.
          len_d = len_clamped;
          if (len_over || mul) begin
            err_d = 1'b1;
          end
          state_d = (len_clamped != '0) ? COPY : DONE;
        end else if (mul) begin
          mul_start = !rst;
          state_d   = MUL;
        end else begin
          pc_en = 1'b1;
          wb_en = 1'b1;
        end
      end
      COPY: begin
        copy_we = 1'b1;
        busy    = 1'b1;
        if (idx_term) begin
          state_d = DONE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (step_term) begin
          state_d = DONE;
        end else begin
          step_inc = 1'b1;
        end
      end
      DONE: begin
        pc_en   = 1'b1;
        wb_en   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign copy_idx = idx_q;
  assign mul_step = step_q;
  assign err      = err_q;

endmodule : multicycle_seq_ctrl

// File: tb/tb_multicycle_seq_ctrl.sv
// Randomized bench for multicycle_seq_ctrl with an instruction-level reference model.
module tb_multicycle_seq_ctrl;

  localparam int unsigned IDX_W      = 32;
  localparam int unsigned MUL_CYCLES = 32;
  localparam int unsigned MAX_LEN    = 1024;
  localparam int unsigned STEP_W     = $clog2(MUL_CYCLES);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              memcopy = 1'b0;
  logic              mul = 1'b0;
  logic [IDX_W-1:0]  copy_len = '0;
  logic              pc_en, wb_en, copy_we, mul_start, busy, done, err;
  logic [IDX_W-1:0]  copy_idx;
  logic [STEP_W-1:0] mul_step;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  multicycle_seq_ctrl #(
    .IDX_W(IDX_W), .MUL_CYCLES(MUL_CYCLES), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst(rst), .memcopy(memcopy), .mul(mul), .copy_len(copy_len),
    .pc_en(pc_en), .wb_en(wb_en), .copy_we(copy_we), .copy_idx(copy_idx),
    .mul_start(mul_start), .mul_step(mul_step), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle.
  typedef struct {
    bit pc_en; bit wb_en; bit copy_we; bit mul_start; bit busy; bit done;
    int idx; int step;
  } exp_t;

  function automatic exp_t mk(bit pc, bit wb, bit we, bit ms, bit bz, bit dn, int idx, int st);
    exp_t e;
    e.pc_en = pc; e.wb_en = wb; e.copy_we = we; e.mul_start = ms;
    e.busy = bz; e.done = dn; e.idx = idx; e.step = st;
    return e;
  endfunction

  // Per-instruction schedule of the cycles still to come; empty means idle.
  exp_t sched[$];
  bit   err_m = 1'b0;

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      bit   err_next;
      int   n;
      err_next = err_m;
      if (rst) begin
        e = mk(!(memcopy || mul), !(memcopy || mul), 0, 0, 0, 0, 0, 0);
        sched.delete();
        err_next = 1'b0;
      end else if (sched.size() > 0) begin
        e = sched.pop_front();
      end else if (memcopy) begin
        n = (copy_len > 32'(MAX_LEN)) ? int'(MAX_LEN) : int'(copy_len);
        e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) sched.push_back(mk(0, 0, 1, 0, 1, 0, i, 0));
        sched.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
        if (copy_len > 32'(MAX_LEN) || mul) err_next = 1'b1;
      end else if (mul) begin
        e = mk(0, 0, 0, 1, 0, 0, 0, 0);
        for (int s = 0; s < int'(MUL_CYCLES); s++) sched.push_back(mk(0, 0, 0, 0, 1, 0, 0, s));
        sched.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
      end else begin
        e = mk(1, 1, 0, 0, 0, 0, 0, 0);
      end

      checks++;
      if (pc_en !== e.pc_en || wb_en !== e.wb_en || copy_we !== e.copy_we ||
          mul_start !== e.mul_start || busy !== e.busy || done !== e.done ||
          err !== err_m ||
          (e.copy_we && int'(copy_idx) != e.idx) ||
          (e.busy && !e.copy_we && int'(mul_step) != e.step)) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got pc=%b wb=%b we=%b idx=%0d ms=%b step=%0d busy=%b done=%b err=%b want pc=%b wb=%b we=%b idx=%0d ms=%b step=%0d busy=%b done=%b err=%b",
                 $time, pc_en, wb_en, copy_we, copy_idx, mul_start, mul_step, busy, done, err,
                 e.pc_en, e.wb_en, e.copy_we, e.idx, e.mul_start, e.step, e.busy, e.done, err_m);
      end
      err_m = err_next;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  // Hold one decode for 'hold' cycles; rst_at>0 pulses rst in that cycle and stops there.
  task automatic run_instr(input bit mc, input bit ml, input logic [IDX_W-1:0] len,
                           input int hold, input int rst_at,
                           output int n_we, output int n_pc_low, output int n_wb_low,
                           output int done_cyc, output int ms_cyc, output int first_idx);
    n_we = 0; n_pc_low = 0; n_wb_low = 0; done_cyc = 0; ms_cyc = 0; first_idx = -1;
    for (int c = 1; c <= hold; c++) begin
      if (c == 1) begin
        memcopy = mc; mul = ml; copy_len = len;
      end else begin
        copy_len = IDX_W'($urandom);
      end
      rst = (c == rst_at);
      @(negedge clk);
      if (copy_we === 1'b1) begin
        if (first_idx < 0) first_idx = int'(copy_idx);
        n_we++;
      end
      if (pc_en !== 1'b1) n_pc_low++;
      if (wb_en !== 1'b1) n_wb_low++;
      if (done === 1'b1 && done_cyc == 0) done_cyc = c;
      if (mul_start === 1'b1 && ms_cyc == 0) ms_cyc = c;
      @(posedge clk);
      #1;
      if (c == rst_at) break;
    end
    rst = 1'b0; memcopy = 1'b0; mul = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; memcopy = 1'b0; mul = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int nwe, npc, nwb, dc, msc, fi;
    int kind, hold, rat, n;
    logic [IDX_W-1:0] len;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_err", int'(err), 0);
    chk("reset_busy", int'(busy), 0);

    // Ordinary instruction passes straight through.
    run_instr(0, 0, 7, 5, 0, nwe, npc, nwb, dc, msc, fi);
    chk("add_pc_low", npc, 0);
    chk("add_done", dc, 0);

    // MEMCOPY of 4 elements.
    run_instr(1, 0, 4, 6, 0, nwe, npc, nwb, dc, msc, fi);
    chk("copy4_we", nwe, 4);
    chk("copy4_pc_low", npc, 5);
    chk("copy4_done_cyc", dc, 6);
    chk("copy4_first_idx", fi, 0);

    // MEMCOPY of zero elements.
    run_instr(1, 0, 0, 2, 0, nwe, npc, nwb, dc, msc, fi);
    chk("copy0_we", nwe, 0);
    chk("copy0_pc_low", npc, 1);
    chk("copy0_done_cyc", dc, 2);

    // MUL.
    run_instr(0, 1, 0, int'(MUL_CYCLES) + 2, 0, nwe, npc, nwb, dc, msc, fi);
    chk("mul_start_cyc", msc, 1);
    chk("mul_done_cyc", dc, 34);
    chk("mul_wb_low", nwb, 33);
    chk("no_err_yet", int'(err), 0);

    // Reset while idx=2 of a 4-element copy, then the same decode restarts.
    run_instr(1, 0, 4, 6, 4, nwe, npc, nwb, dc, msc, fi);
    chk("rst_mid_we", nwe, 2);
    chk("rst_mid_done", dc, 0);
    run_instr(1, 0, 4, 6, 0, nwe, npc, nwb, dc, msc, fi);
    chk("restart_first_idx", fi, 0);
    chk("restart_done_cyc", dc, 6);

    // Oversized copy is clamped and flagged.
    run_instr(1, 0, 5000, int'(MAX_LEN) + 2, 0, nwe, npc, nwb, dc, msc, fi);
    chk("clamp_we", nwe, 1024);
    chk("clamp_done_cyc", dc, 1026);
    chk("clamp_err", int'(err), 1);
    do_reset();
    chk("err_cleared", int'(err), 0);

    // Both decodes: MEMCOPY path plus error.
    run_instr(1, 1, 3, 5, 0, nwe, npc, nwb, dc, msc, fi);
    chk("both_we", nwe, 3);
    chk("both_mul_start", msc, 0);
    chk("both_done_cyc", dc, 5);
    chk("both_err", int'(err), 1);
    do_reset();

    // Random instruction stream, checked by the model every cycle.
    for (int k = 0; k < 80; k++) begin
      kind = int'($urandom_range(0, 3));
      case ($urandom_range(0, 19))
        0:       len = '0;
        1:       len = 1;
        2:       len = IDX_W'(MAX_LEN + $urandom_range(1, 50));
        3:       len = IDX_W'(MAX_LEN);
        default: len = IDX_W'($urandom_range(2, 20));
      endcase
      n = (len > IDX_W'(MAX_LEN)) ? int'(MAX_LEN) : int'(len);
      case (kind)
        0:       hold = int'($urandom_range(1, 3));
        1, 3:    hold = n + 2;
        default: hold = int'(MUL_CYCLES) + 2;
      endcase
      rat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, hold)) : 0;
      run_instr(kind == 1 || kind == 3, kind == 2 || kind == 3, len, hold, rat,
                nwe, npc, nwb, dc, msc, fi);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multicycle_seq_ctrl

// File: doc/multicycle_seq_ctrl.md
# multicycle_seq_ctrl

Sequencer for the processor's multi-cycle instructions (MEMCOPY and MUL). It sits beside the main controller and replaces the ad-hoc top-level iteration counters. It holds the PC while a multi-cycle instruction runs, steps the copy index or multiplier step, and gates register writeback so the instruction retires exactly once. All other instructions pass through with zero added latency.

## Interface
Parameters:
- IDX_W, 32, width of copy length and copy index
- MUL_CYCLES, 32, number of multiplier iteration cycles (≥2)
- MAX_LEN, 1024, largest accepted copy length; larger requests are clamped

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- memcopy  in  1  decoded MEMCOPY from main controller (level, valid while instruction held)
- mul  in  1  decoded MUL from main controller
- copy_len  in  IDX_W  element count for MEMCOPY (register-file rs1 read)
- pc_en  out  1  PC update enable
- wb_en  out  1  register-file write gate, ANDed with controller RegWrite
- copy_we  out  1  copy-engine step strobe
- copy_idx  out  IDX_W  current copy element index
- mul_start  out  1  one-cycle multiplier start pulse
- mul_step  out  $clog2(MUL_CYCLES)  current multiplier iteration
- busy  out  1  high in COPY or MUL
- done  out  1  one-cycle retire pulse for a multi-cycle instruction
- err  out  1  sticky; set on clamp or on memcopy&mul both high; cleared only by rst

## Operation
- States: IDLE, COPY, MUL, DONE.
- IDLE, no multi-cycle decode: pc_en=1, wb_en=1, all strobes 0.
- IDLE, memcopy=1:
  - Latch len_q = min(copy_len, MAX_LEN); set err if clamped.
  - pc_en=0, wb_en=0.
  - len_q≠0 → COPY with idx=0; len_q=0 → DONE.
- IDLE, mul=1 (memcopy=0): mul_start=1, pc_en=0, wb_en=0, step=0, → MUL.
- memcopy and mul both 1 in IDLE: treat as MEMCOPY and set err.
- COPY: copy_we=1, copy_idx=idx, pc_en=0, wb_en=0. If idx==len_q−1, go to DONE; otherwise idx+1.
- MUL: mul_step=step, pc_en=0, wb_en=0. If step==MUL_CYCLES−1, go to DONE; otherwise step+1.
- DONE: pc_en=1, wb_en=1, done=1, → IDLE unconditionally. memcopy/mul are ignored here because the same instruction is still decoded.
- Outputs are combinational from state, counters and decode inputs; counters and len_q are registered.
- Counters never wrap: the length is clamped, so idx stays below MAX_LEN.

## Timing
- Non-multi-cycle instruction: 0 extra cycles.
- MEMCOPY, length N (1..MAX_LEN): N+2 cycles total (decode, N copy cycles, DONE). copy_we is high for exactly N cycles with idx 0..N−1.
- MEMCOPY, length 0: 2 cycles (decode, DONE). copy_we is never asserted.
- MUL: MUL_CYCLES+2 cycles. mul_start fires in the decode cycle, one cycle before step 0.
- copy_len is sampled only in the IDLE decode cycle; later changes are ignored.
- rst high on any edge: state=IDLE, idx=0, step=0, len_q=0, err=0.
  - In the reset cycle, outputs follow the IDLE equations: pc_en=1 and wb_en=1 when no decode is present, all strobes, busy and done 0.
  - Reset mid-COPY/MUL abandons the instruction; no done pulse is issued.
- Back-to-back multi-cycle instructions: DONE → IDLE → new decode. There is no bubble beyond DONE.

## Structure
- Shared package `mcseq_pkg`:
  - `mcseq_state_t` enum {IDLE, COPY, MUL, DONE}
  - default constants DEF_MUL_CYCLES=32 and DEF_MAX_LEN=1024
- One natural sub-module: `step_counter` (load-zero, increment, terminal-count compare), instantiated twice for idx and step.
- The top level of the processor drives pc_en into the PC counter and ANDs wb_en with RegWrite.

## Test plan
- Reset, then an ADD decode (memcopy=mul=0) → pc_en=1, wb_en=1 every cycle, busy=0, done never.
- memcopy=1, copy_len=4 → copy_we high 4 cycles with idx 0,1,2,3; pc_en low 5 cycles; done and wb_en high in cycle 6; back to IDLE in cycle 7.
- memcopy=1, copy_len=0 → cycle 1 pc_en=0, no copy_we; cycle 2 done=1, pc_en=1.
- mul=1, MUL_CYCLES=32 → mul_start in cycle 1; mul_step 0..31 in cycles 2..33; done in cycle 34; wb_en low in cycles 1..33.
- memcopy=1, copy_len=5000 → err=1, exactly 1024 copy_we pulses, done after 1026 cycles. memcopy&mul together → err=1 and the MEMCOPY path is taken.
- rst asserted at idx=2 of a 4-element copy → next cycle IDLE, copy_we=0, no done. Re-decoding the same MEMCOPY restarts at idx=0.
